// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline hazard and stall controller for a 5-stage core.
//
// Detects load-use hazards between EX and ID and handles ID-resolved redirects.
// It also stalls the front end around instruction and data memory misses.
// The control outputs are combinational, computed from the registered FSM state
// and the current inputs. The FSM state is RUN, IWAIT (waiting on imem) or
// DWAIT (waiting on dmem).
//
// Optional feature: define STALL_CNT_EN to build saturating performance
// counters. Without it, Stall_Cycles and Flush_Count are tied to zero.
//
// Ports:
//   CLK, RESET            clock; asynchronous active-high reset
//   ID_Rs, ID_Rt          source registers of the instruction in ID
//   ID_UsesRt             ID instruction reads Rt
//   EX_MemRead, EX_Rt     load in EX and its destination register
//   ID_Redirect           taken branch/jump resolved in ID
//   IMEM_Ready            instruction memory ready
//   DMEM_Req, DMEM_Ready  data memory request / ready
//   PCWrite, IFIDWrite    pipeline advance enables
//   IF_Flush, IDEX_Bubble squash IF/ID, insert bubble into ID/EX
//   MEM_Hold, IMEM_Abort  freeze MEM stage, abandon outstanding fetch
//   Ctrl_State            RUN=0, IWAIT=1, DWAIT=2
//   Stall_Cycles          cycles with PCWrite=0 (saturating)
//   Flush_Count           cycles with IF_Flush=1 (saturating)
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             ID_Redirect,
  input  logic             IMEM_Ready,
  input  logic             DMEM_Req,
  input  logic             DMEM_Ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IF_Flush,
  output logic             IDEX_Bubble,
  output logic             MEM_Hold,
  output logic             IMEM_Abort,
  output logic [1:0]       Ctrl_State,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IWAIT   = 2'd1,
    DWAIT   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t state, state_next;
  logic   load_use;
  logic   dmem_miss;
  logic   imem_miss;

  // r0 is hardwired to zero, so a load into r0 never creates a hazard.
  assign load_use  = EX_MemRead && (EX_Rt != 5'd0) &&
                     ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  assign dmem_miss = DMEM_Req && !DMEM_Ready;
  assign imem_miss = !IMEM_Ready;

  // NOTE: every output gets a default before the case statement. This keeps
  // the block purely combinational, so no latch can be inferred.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IF_Flush    = 1'b0;
    IDEX_Bubble = 1'b0;
    MEM_Hold    = 1'b0;
    IMEM_Abort  = 1'b0;
    state_next  = RUN;
    if (RESET) begin
      // Hold the front end and feed bubbles while in reset.
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEX_Bubble = 1'b1;
    end else begin
      unique case (state)
        DWAIT: begin
          if (!DMEM_Ready) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            MEM_Hold   = 1'b1;
            state_next = DWAIT;
          end
        end
        IWAIT: begin
          // A redirect makes the pending fetch useless, so abandon it.
          if (ID_Redirect) begin
            IMEM_Abort = 1'b1;
            IF_Flush   = 1'b1;
          end else if (imem_miss) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            state_next  = IWAIT;
          end
        end
        default: begin  // RUN, and the unreachable encoding behaves as RUN
          if (dmem_miss) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            MEM_Hold   = 1'b1;
            state_next = DWAIT;
          end else if (load_use) begin
            // The stalled branch in ID is re-evaluated next cycle, so it
            // must not flush IF yet.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
          end else if (ID_Redirect) begin
            IF_Flush = 1'b1;
          end else if (imem_miss) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            state_next  = IWAIT;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples its pre-edge value, and simulation matches the synthesized logic.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= RUN;
    else       state <= state_next;
  end

  assign Ctrl_State = state;

`ifdef STALL_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Stall_Cycles <= '0;
      Flush_Count  <= '0;
    end else begin
      if (!PCWrite && (Stall_Cycles != '1)) Stall_Cycles <= Stall_Cycles + CNT_W'(1);
      if (IF_Flush && (Flush_Count != '1))  Flush_Count  <= Flush_Count + CNT_W'(1);
    end
  end
`else
  assign Stall_Cycles = '0;
  assign Flush_Count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (CNT_W=4, so counter saturation
// can be reached quickly). The reference model is written from the behavioural
// rules: mode 0/1/2 = run/iwait/dwait, and the counters are plain saturating ints.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SNAP_W  = 8 + 2 * CNT_W;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [4:0]       ID_Rs, ID_Rt, EX_Rt;
  logic             ID_UsesRt, EX_MemRead, ID_Redirect;
  logic             IMEM_Ready, DMEM_Req, DMEM_Ready;
  logic             PCWrite, IFIDWrite, IF_Flush, IDEX_Bubble, MEM_Hold, IMEM_Abort;
  logic [1:0]       Ctrl_State;
  logic [CNT_W-1:0] Stall_Cycles, Flush_Count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int       m_mode, m_stall, m_flush, exp_next;
  bit [5:0] exp_ctl;  // {PCWrite,IFIDWrite,IF_Flush,IDEX_Bubble,MEM_Hold,IMEM_Abort}

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .ID_Redirect(ID_Redirect),
    .IMEM_Ready(IMEM_Ready), .DMEM_Req(DMEM_Req), .DMEM_Ready(DMEM_Ready),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IF_Flush(IF_Flush),
    .IDEX_Bubble(IDEX_Bubble), .MEM_Hold(MEM_Hold), .IMEM_Abort(IMEM_Abort),
    .Ctrl_State(Ctrl_State), .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [SNAP_W-1:0] dut_snap();
    return {PCWrite, IFIDWrite, IF_Flush, IDEX_Bubble, MEM_Hold, IMEM_Abort,
            Ctrl_State, Stall_Cycles, Flush_Count};
  endfunction

  function automatic logic [SNAP_W-1:0] exp_snap();
    return {exp_ctl, 2'(m_mode), CNT_W'(m_stall), CNT_W'(m_flush)};
  endfunction

  // Expected outputs and next mode for the current inputs.
  task automatic model_eval();
    bit lu;
    lu = EX_MemRead && (EX_Rt != 0) &&
         ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
    exp_ctl  = 6'b110000;
    exp_next = 0;
    if (RESET) exp_ctl = 6'b000100;
    else if (m_mode == 2) begin
      if (!DMEM_Ready) begin exp_ctl = 6'b000010; exp_next = 2; end
    end else if (m_mode == 1) begin
      if (ID_Redirect)      exp_ctl = 6'b111001;
      else if (!IMEM_Ready) begin exp_ctl = 6'b000100; exp_next = 1; end
    end else begin
      if (DMEM_Req && !DMEM_Ready) begin exp_ctl = 6'b000010; exp_next = 2; end
      else if (lu)          exp_ctl = 6'b000100;
      else if (ID_Redirect) exp_ctl = 6'b111000;
      else if (!IMEM_Ready) begin exp_ctl = 6'b000100; exp_next = 1; end
    end
  endtask

  // Clock edge: update the model the way the spec says state and counters move.
  task automatic advance();
    @(posedge CLK);
    if (!RESET) begin
`ifdef STALL_CNT_EN
      if (!exp_ctl[5] && m_stall < CNT_MAX) m_stall++;
      if (exp_ctl[3] && m_flush < CNT_MAX)  m_flush++;
`endif
      m_mode = exp_next;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRt = 1'b0; EX_MemRead = 1'b0; EX_Rt = 5'd0;
    ID_Redirect = 1'b0; IMEM_Ready = 1'b1; DMEM_Req = 1'b0; DMEM_Ready = 1'b1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    m_mode = 0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    idle_inputs();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle_inputs();
    m_mode = 0; m_stall = 0; m_flush = 0;
    #2 model_eval();
    n_cmp++;
    if (dut_snap() !== exp_snap()) begin
      n_bad++; $display("FAIL reset_hold got %h want %h", dut_snap(), exp_snap());
    end
    // Miss and hazard inputs must not matter while reset is held.
    DMEM_Req = 1'b1; DMEM_Ready = 1'b0; IMEM_Ready = 1'b0; ID_Redirect = 1'b1;
    advance();
    model_eval();
    n_cmp++;
    if (dut_snap() !== exp_snap()) begin
      n_bad++; $display("FAIL reset_inputs got %h want %h", dut_snap(), exp_snap());
    end
    advance();
    RESET = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    // {mr, ex_rt, rs, rt, uses_rt, redirect}
    logic [19:0] rows [7];
    rows[0] = {1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0};  // hazard on Rs
    rows[1] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0};  // r0 never stalls
    rows[2] = {1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0};  // hazard on Rt
    rows[3] = {1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0};  // Rt not read
    rows[4] = {1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0};  // not a load
    rows[5] = {1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1};  // hazard beats redirect
    rows[6] = {1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1};  // redirect alone flushes
    do_reset();
    for (int i = 0; i < 7; i++) begin
      {EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt, ID_Redirect} = rows[i];
      #1 model_eval();
      n_cmp++;
      if (dut_snap() !== exp_snap()) begin
        n_bad++; $display("FAIL load_use[%0d] got %h want %h", i, dut_snap(), exp_snap());
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_dmem_wait();
    int holds = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      DMEM_Req    = (i < 5);
      DMEM_Ready  = (i >= 4);
      ID_Redirect = 1'($urandom);   // ignored in DWAIT
      EX_MemRead  = 1'b0;
      IMEM_Ready  = 1'($urandom);
      if (i == 0) begin ID_Redirect = 1'b0; IMEM_Ready = 1'b1; end
      #1 model_eval();
      n_cmp++;
      if (dut_snap() !== exp_snap()) begin
        n_bad++; $display("FAIL dmem[%0d] got %h want %h", i, dut_snap(), exp_snap());
      end
      if (MEM_Hold) holds++;
      if (i == 5) break;
      advance();
    end
    n_cmp++;
    if (holds !== 4) begin
      n_bad++; $display("FAIL dmem_hold_cycles got %0d want 4", holds);
    end
    n_cmp++;
`ifdef STALL_CNT_EN
    if (Stall_Cycles !== CNT_W'(4)) begin
      n_bad++; $display("FAIL dmem_stall_count got %0d want 4", Stall_Cycles);
    end
`else
    if (Stall_Cycles !== '0) begin
      n_bad++; $display("FAIL dmem_stall_count got %0d want 0", Stall_Cycles);
    end
`endif
    advance();
    idle_inputs();
  endtask

  task automatic test_iwait_abort();
    int aborts = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      IMEM_Ready  = (i >= 3);
      ID_Redirect = (i == 2);
      #1 model_eval();
      n_cmp++;
      if (dut_snap() !== exp_snap()) begin
        n_bad++; $display("FAIL iwait[%0d] got %h want %h", i, dut_snap(), exp_snap());
      end
      if (IMEM_Abort) aborts++;
      advance();
    end
    n_cmp++;
    if (aborts !== 1 || Ctrl_State !== 2'd0) begin
      n_bad++; $display("FAIL iwait_abort got aborts=%0d st=%0d want 1/0", aborts, Ctrl_State);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    DMEM_Req = 1'b1; DMEM_Ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 model_eval();
      advance();
    end
    #2 RESET = 1'b1;                  // asynchronous, mid-cycle
    m_mode = 0; m_stall = 0; m_flush = 0;
    #1 model_eval();
    n_cmp++;
    if (dut_snap() !== exp_snap()) begin
      n_bad++; $display("FAIL reset_mid_dwait got %h want %h", dut_snap(), exp_snap());
    end
    @(posedge CLK);
    #1 RESET = 1'b0;
    DMEM_Req = 1'b0; DMEM_Ready = 1'b0;  // held in DWAIT this would stall
    #1 model_eval();
    n_cmp++;
    if (dut_snap() !== exp_snap()) begin
      n_bad++; $display("FAIL after_reset_run got %h want %h", dut_snap(), exp_snap());
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    IMEM_Ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1 model_eval();
      n_cmp++;
      if (dut_snap() !== exp_snap()) begin
        n_bad++; $display("FAIL sat[%0d] got %h want %h", i, dut_snap(), exp_snap());
      end
      advance();
    end
    n_cmp++;
`ifdef STALL_CNT_EN
    if (Stall_Cycles !== CNT_W'(CNT_MAX)) begin
      n_bad++; $display("FAIL stall_saturate got %0d want %0d", Stall_Cycles, CNT_MAX);
    end
`else
    if (Stall_Cycles !== '0) begin
      n_bad++; $display("FAIL stall_saturate got %0d want 0", Stall_Cycles);
    end
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (RESET && ($urandom_range(1) == 0)) RESET = 1'b0;
      else if ($urandom_range(49) == 0) begin
        RESET = 1'b1;
        m_mode = 0; m_stall = 0; m_flush = 0;
      end
      ID_Rs       = 5'($urandom_range(3));
      ID_Rt       = 5'($urandom_range(3));
      EX_Rt       = 5'($urandom_range(3));
      ID_UsesRt   = 1'($urandom);
      EX_MemRead  = 1'($urandom);
      ID_Redirect = ($urandom_range(3) == 0);
      IMEM_Ready  = ($urandom_range(3) != 0);
      DMEM_Req    = ($urandom_range(9) < 3);
      DMEM_Ready  = 1'($urandom);
      #1 model_eval();
      n_cmp++;
      if (dut_snap() !== exp_snap()) begin
        n_bad++; $display("FAIL rand[%0d] got %h want %h", i, dut_snap(), exp_snap());
      end
      if ((IF_Flush && IFIDWrite && !PCWrite) || (MEM_Hold && PCWrite)) begin
        n_bad++; $display("FAIL rand_invariant[%0d] ctl=%b", i,
                          {PCWrite, IFIDWrite, IF_Flush, IDEX_Bubble, MEM_Hold, IMEM_Abort});
      end
      advance();
    end
    RESET = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_iwait_abort();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
